// File: rtl/maq_pkg.sv
// Shared types and helpers for the BCD clock-chain counters.
// Provides the BCD digit type, standard moduli and BCD-to-binary.
package maq_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam int SEC_MOD    = 60;
  localparam int MIN_MOD    = 60;
  localparam int HOUR24_MOD = 24;
  localparam int HOUR12_MOD = 12;

  // 10*msd + lsd in 7 bits; 9*10+15 = 105 still fits.
  function automatic logic [6:0] bcd_to_bin(bcd_t msd, bcd_t lsd);
    logic [6:0] m7;
    logic [6:0] l7;
    m7 = {3'b000, msd};
    l7 = {3'b000, lsd};
    return (m7 * 7'd10) + l7;
  endfunction

endpackage

// File: rtl/bcd_digit_updn.sv
// One BCD digit register with set / clear / increment / decrement.
// Ports: clk, rst_n, set+set_val, clr, inc, dec (one-hot), q.
module bcd_digit_updn
  import maq_pkg::*;
#(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         set,
  input  logic [W-1:0] set_val,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    unique case (1'b1)
      set:     q_d = set_val;
      clr:     q_d = '0;
      inc:     q_d = q_q + W'(1);
      dec:     q_d = q_q - W'(1);
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_VAL;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/maq_bcd_mod.sv
// Two-digit BCD modulo counter stage, up/down, loadable, chainable.
// Ports: step in (enable/incremento/down), load in, digits/tc/carry/load_err out.
module maq_bcd_mod
  import maq_pkg::*;
#(
  parameter int MODULUS     = 60,
  parameter int RESET_VALUE = 59,
  parameter int MSD_W       = 3
) (
  input  logic             maqb_clock,
  input  logic             maqb_reset,
  input  logic             maqb_enable,
  input  logic             maqb_incremento,
  input  logic             maqb_down,
  input  logic             maqb_load,
  input  logic [3:0]       maqb_load_Lsd,
  input  logic [MSD_W-1:0] maqb_load_Msd,
  output logic [3:0]       maqb_Lsd,
  output logic [MSD_W-1:0] maqb_Msd,
  output logic             maqb_tc,
  output logic             maqb_carry,
  output logic             maqb_load_err
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_mod
    $error("maq_bcd_mod: MODULUS must be 2..100");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_rst
    $error("maq_bcd_mod: RESET_VALUE must be < MODULUS");
  end
  if (MSD_W < 1 || MSD_W > 4
      || ((MODULUS - 1) / 10) >= (1 << MSD_W)) begin : g_bad_w
    $error("maq_bcd_mod: MSD_W too narrow or wider than a BCD digit");
  end

  localparam logic [6:0]       MAX_V = 7'(MODULUS - 1);
  localparam bcd_t             MAX_L = 4'((MODULUS - 1) % 10);
  localparam logic [MSD_W-1:0] MAX_M = MSD_W'((MODULUS - 1) / 10);
  localparam bcd_t             RST_L = 4'(RESET_VALUE % 10);
  localparam logic [MSD_W-1:0] RST_M = MSD_W'(RESET_VALUE / 10);

  logic [3:0]       lsd;
  logic [MSD_W-1:0] msd;
  logic [6:0]       val;
  logic [6:0]       ld_val;
  logic             step;
  logic             at_zero;
  logic             at_max;
  logic             load_ok;

  logic             l_set, l_clr, l_inc, l_dec;
  logic             m_set, m_clr, m_inc, m_dec;
  bcd_t             l_set_val;
  logic [MSD_W-1:0] m_set_val;

  logic             load_err_q;
  logic             load_err_d;

  assign val     = bcd_to_bin(4'(msd), lsd);
  assign ld_val  = bcd_to_bin(4'(maqb_load_Msd), maqb_load_Lsd);
  assign at_zero = (val == 7'd0);
  assign at_max  = (val == MAX_V);
  assign step    = maqb_enable & maqb_incremento & ~maqb_load;

  assign load_ok = (maqb_load_Lsd <= BCD_MAX)
                 & (4'(maqb_load_Msd) <= BCD_MAX)
                 & (ld_val <= MAX_V);

  assign maqb_tc    = maqb_down ? at_zero : at_max;
  assign maqb_carry = step & maqb_tc;

  // Wrap is decided on the full value; digit rollover only inside range.
  always_comb begin
    l_set     = 1'b0;
    l_clr     = 1'b0;
    l_inc     = 1'b0;
    l_dec     = 1'b0;
    m_set     = 1'b0;
    m_clr     = 1'b0;
    m_inc     = 1'b0;
    m_dec     = 1'b0;
    l_set_val = BCD_MAX;
    m_set_val = MAX_M;
    if (maqb_load) begin
      l_set     = load_ok;
      m_set     = load_ok;
      l_set_val = maqb_load_Lsd;
      m_set_val = maqb_load_Msd;
    end else if (step && !maqb_down) begin
      if (at_max) begin
        l_clr = 1'b1;
        m_clr = 1'b1;
      end else if (lsd == BCD_MAX) begin
        l_clr = 1'b1;
        m_inc = 1'b1;
      end else begin
        l_inc = 1'b1;
      end
    end else if (step) begin
      if (at_zero) begin
        l_set     = 1'b1;
        m_set     = 1'b1;
        l_set_val = MAX_L;
      end else if (lsd == 4'd0) begin
        l_set = 1'b1;
        m_dec = 1'b1;
      end else begin
        l_dec = 1'b1;
      end
    end
  end

  assign load_err_d = maqb_load & ~load_ok;

  always_ff @(posedge maqb_clock or negedge maqb_reset) begin
    if (!maqb_reset) load_err_q <= 1'b0;
    else             load_err_q <= load_err_d;
  end

  bcd_digit_updn #(
    .W       (4),
    .RST_VAL (RST_L)
  ) u_lsd (
    .clk     (maqb_clock),
    .rst_n   (maqb_reset),
    .set     (l_set),
    .set_val (l_set_val),
    .clr     (l_clr),
    .inc     (l_inc),
    .dec     (l_dec),
    .q       (lsd)
  );

  bcd_digit_updn #(
    .W       (MSD_W),
    .RST_VAL (RST_M)
  ) u_msd (
    .clk     (maqb_clock),
    .rst_n   (maqb_reset),
    .set     (m_set),
    .set_val (m_set_val),
    .clr     (m_clr),
    .inc     (m_inc),
    .dec     (m_dec),
    .q       (msd)
  );

  assign maqb_Lsd      = lsd;
  assign maqb_Msd      = msd;
  assign maqb_load_err = load_err_q;

endmodule

// File: doc/maq_bcd_mod.md
Name: maq_bcd_mod

Overview:
Parametrised two-digit BCD modulo counter, the generalised successor of the fixed 00–59 minutes stage. It serves as seconds/minutes (MODULUS=60) or hours (MODULUS=24/12) in the clock chain. Additions over the fixed stage:
- configurable modulus and reset value
- up/down counting
- synchronous load for time-setting, with range checking
- a qualified carry/borrow pulse that chains stage to stage

Parameters:
MODULUS, 60, count range 0..MODULUS-1; legal 2..100
RESET_VALUE, 59, binary value loaded at reset; must be < MODULUS
MSD_W, 3, width of tens digit; must satisfy (MODULUS-1)/10 < 2**MSD_W

Ports:
maqb_clock  in  1  system clock, rising edge
maqb_reset  in  1  asynchronous, active-low reset
maqb_enable  in  1  stage enable; gates stepping only, not load
maqb_incremento  in  1  one-cycle step pulse from the previous stage or tick source
maqb_down  in  1  0 = count up, 1 = count down; sampled with the step
maqb_load  in  1  synchronous load strobe
maqb_load_Lsd  in  4  units digit to load
maqb_load_Msd  in  MSD_W  tens digit to load
maqb_Lsd  out  4  units digit (BCD)
maqb_Msd  out  MSD_W  tens digit (BCD)
maqb_tc  out  1  terminal count for the current direction (combinational)
maqb_carry  out  1  qualified carry/borrow to the next stage (combinational)
maqb_load_err  out  1  registered one-cycle pulse on a rejected load

Behaviour:
- Reset: when maqb_reset=0, asynchronously set Msd=RESET_VALUE/10, Lsd=RESET_VALUE%10, load_err=0. With defaults the digits read 5/9.
- Value V = 10*Msd + Lsd. It is always a legal BCD value < MODULUS after reset. No illegal state is reachable.
- Step condition: step = enable & incremento & ~load. Digits update on the next rising edge, giving 1-cycle latency to the outputs.
- Up step:
  - V=MODULUS-1 → 0.
  - Otherwise, Lsd=9 → Lsd=0 and Msd+1.
  - Otherwise Lsd+1.
- Down step:
  - V=0 → MODULUS-1.
  - Otherwise, Lsd=0 → Lsd=9 and Msd-1.
  - Otherwise Lsd-1.
- Wrap is decided on the full value, never per digit. Example: MODULUS=24 wraps 23→00, not 29→00.
- tc = down ? (V==0) : (V==MODULUS-1). It is purely combinational and independent of enable and incremento.
- carry = step & tc. The next stage steps in the same cycle this stage wraps, so chained stages wrap on the same edge. No added latency per stage.
- Load has priority over step, and enable does not gate it.
  - On load, the operands are checked: Lsd<=9, Msd<=9, and 10*Msd+Lsd < MODULUS.
  - Valid load: the digits take the load values next edge and load_err=0.
  - Invalid load: the digits hold and load_err=1 for exactly one cycle.
- A step coinciding with a load is dropped; carry=0 in that cycle.
- Direction changes take effect on the first step after the change; there is no state tied to direction.
- Reset mid-operation (including during load): the async reset overrides everything. The first edge after release performs no step unless incremento is high.
- incremento held high with enable=1 steps every cycle; the counter is level-sensitive per cycle and has no edge detection.
- Arithmetic: compute V in 7 bits. Digit arithmetic stays within 4 bits or MSD_W bits; no overflow is possible given the parameter rules.
- Elaboration: assert on illegal parameter combinations: MODULUS out of range, RESET_VALUE>=MODULUS, or MSD_W too narrow.

Decomposition:
- Package maq_pkg holds:
  - BCD digit typedef (logic [3:0])
  - BCD_MAX=9
  - localparams for standard moduli: SEC_MOD=60, MIN_MOD=60, HOUR24_MOD=24, HOUR12_MOD=12
  - a function bcd_to_bin(msd,lsd)
- Optional sub-module bcd_digit_updn: one BCD digit holding inc/dec/clear/set-to-value controls. Instantiate it twice. Wrap decisions remain in maq_bcd_mod.

Test Plan:
- Reset release with defaults → Msd=5, Lsd=9, tc=1 while down=0. A single step (enable=1, incremento=1) → outputs 0/0, carry=1 during that cycle only.
- MODULUS=24, RESET_VALUE=0, 23 up-steps → 2/3 with tc=1. One more step → 0/0, carry pulses once. Lsd never exceeds 3 while Msd=2.
- Down count MODULUS=60 starting at 1/0 → 0/9 (tens borrow). Continue to 0/0 with tc=1. Next step → 5/9, carry=1.
- Load 4/2 (MODULUS=60) simultaneous with incremento=1, enable=0 → 4/2 next cycle, carry=0, load_err=0. Load 6/0 → digits unchanged, load_err=1 for one cycle. Load Lsd=A → rejected, same as previous case.
- incremento=1 with enable=0 for 10 cycles → value unchanged, carry=0. tc still tracks the value.
- Assert reset asynchronously mid-count at 3/7, between clock edges → digits become 5/9 immediately without a clock edge. Release, then first step → 0/0.
